recon_frame_filter: RTL and testbench
=====================================

Name: recon_frame_filter

Overview:
- Ingress stage directly upstream of the bitstream stream-capture block.
- Inspects the first beat of every AXI-Stream frame from the MAC/RX path: Ethernet II, IPv4, UDP, destination port.
- Forwards matching reconfiguration frames unmodified through a 2-entry skid buffer; silently drops all other frames.
- Downstream capture logic therefore sees only well-formed reconfiguration traffic, with the 46-byte Eth/IP/RMT header and 8-byte recon header in the first beat.

Parameters:
- DATA_WIDTH, 512, tdata width in bits; must be ≥ 512 so bytes 0..53 fit in beat 0.
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width.
- RECON_UDP_PORT, 16'h4D52, UDP destination port identifying reconfiguration frames.
- MIN_HDR_BYTES, 54, contiguous bytes from byte 0 that beat 0 tkeep must cover.

Ports:
- clk  in  1  clock for all logic
- rst  in  1  synchronous active-high reset
- s_axis_tdata  in  DATA_WIDTH  input frame data; byte n = tdata[8n+:8]
- s_axis_tkeep  in  KEEP_WIDTH  byte enables
- s_axis_tvalid  in  1  input valid
- s_axis_tlast  in  1  last beat of frame
- s_axis_tready  out  1  input ready
- m_axis_tdata  out  DATA_WIDTH  forwarded data
- m_axis_tkeep  out  KEEP_WIDTH  forwarded byte enables
- m_axis_tvalid  out  1  output valid
- m_axis_tlast  out  1  output last
- m_axis_tready  in  1  downstream ready
- frame_pass  out  1  one-cycle pulse when a frame's first beat is accepted as PASS
- frame_drop  out  1  one-cycle pulse when a frame's first beat is classified DROP

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values:
  - m_axis_tvalid = 0, frame_pass = 0, frame_drop = 0.
  - s_axis_tready = 0 during reset; 1 in the first cycle after reset.
  - FSM = HEAD; skid buffer empty.
- Match condition, evaluated combinationally on beat 0:
  - {b12,b13} == 16'h0800
  - b14[7:4] == 4
  - b23 == 8'd17
  - {b36,b37} == RECON_UDP_PORT
  - tkeep[MIN_HDR_BYTES-1:0] all ones
- FSM states:
  - HEAD: waiting for beat 0.
    - Accepted beat, match and !tlast -> PASS.
    - Accepted beat, match and tlast -> stay HEAD; beat is forwarded.
    - Accepted beat, no match and !tlast -> DROP.
    - Accepted beat, no match and tlast -> stay HEAD; beat is discarded.
  - PASS: forward each accepted beat; tlast -> HEAD.
  - DROP: discard each accepted beat; tlast -> HEAD.
- Handshake:
  - s_axis_tready = 1 in DROP, and in HEAD when the skid buffer is not full.
  - In PASS, s_axis_tready = skid buffer not full.
  - Classification of beat 0 uses the same cycle's data, so ready must not depend on the match result.
  - In HEAD, ready = skid buffer not full, even for beats that will be dropped.
- Skid buffer:
  - Registered output, 2 entries.
  - Latency input-to-m_axis_tvalid = 1 cycle.
  - Full throughput: 1 beat/cycle with m_axis_tready held high.
  - tdata, tkeep and tlast are passed bit-exact; no header stripping.
- Pulses: frame_pass / frame_drop are registered and assert the cycle after beat-0 acceptance.
- Beats with tvalid=0 never advance the FSM.
- tkeep of non-first beats is not checked.
- Reset mid-frame:
  - FSM returns to HEAD and the skid buffer is flushed.
  - A partially forwarded frame is truncated without tlast; downstream reset is required alongside this block.
  - The remainder of an interrupted input frame is then parsed as a new frame, and normally fails the match.
- Back-pressure: while m_axis_tready = 0 and the buffer is full, no input is accepted in HEAD/PASS; the FSM holds.

Optional Feature:
- Macro RECON_FILTER_STATS_EN.
- Defined:
  - Adds outputs stat_pass_cnt[31:0] and stat_drop_cnt[31:0], both reset to 0.
  - Each increments on the corresponding pulse and saturates at 32'hFFFFFFFF (no wrap).
  - Adds input stat_clr, which zeroes both counters synchronously; clear has priority over a same-cycle increment.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package recon_pkg:
  - Header byte-offset constants: ETH_TYPE_OFS=12, IP_VER_OFS=14, IP_PROTO_OFS=23, UDP_DPORT_OFS=36, RMT_HDR_BYTES=46, RECON_HDR_BYTES=8.
  - ETHERTYPE_IPV4, IPPROTO_UDP.
  - FSM state enum {HEAD, PASS, DROP}.
- Sub-module axis_skid_buf: the 2-entry registered buffer, parameterised on DATA_WIDTH/KEEP_WIDTH.

Test Plan:
- Matching 3-beat frame (ethertype 0x0800, proto 17, dport 0x4D52, tkeep beat0 all ones), m_axis_tready=1 -> same 3 beats out, 1-cycle latency, frame_pass pulses once, tlast on beat 3.
- Frame with dport 0x1234, 4 beats -> no m_axis_tvalid; s_axis_tready high throughout; frame_drop pulses once; a following matching frame is forwarded intact.
- Single-beat matching frame with tkeep = 54 ones -> forwarded; with tkeep = 53 ones -> dropped (runt).
- Back-to-back matching frames with m_axis_tready toggling 1,0,0,1 -> no beat lost or duplicated; s_axis_tready deasserts while the buffer is full.
- rst asserted during beat 2 of a 5-beat PASS frame -> m_axis_tvalid=0 next cycle, FSM in HEAD; the next matching frame passes.
- With RECON_FILTER_STATS_EN: 3 passes and 2 drops -> stat_pass_cnt=3, stat_drop_cnt=2; stat_clr in the same cycle as a pass -> both counters 0.

Source files
------------

// File: rtl/recon_pkg.sv
// ---------------------------------------------------------------------------
// recon_pkg
// Shared constants and types for the reconfiguration frame filter.
//   - Byte offsets of the header fields inspected in beat 0
//     (Ethernet II / IPv4 / UDP), plus the RMT and recon header sizes.
//   - Field values identifying an IPv4/UDP frame.
//   - Frame-classification FSM state type.
// ---------------------------------------------------------------------------
package recon_pkg;

   // Byte offsets from the start of the frame (byte n = tdata[8n+:8]).
   localparam int ETH_TYPE_OFS    = 12;
   localparam int IP_VER_OFS      = 14;
   localparam int IP_PROTO_OFS    = 23;
   localparam int UDP_DPORT_OFS   = 36;

   // Eth/IP/RMT header followed by the 8-byte recon header.
   localparam int RMT_HDR_BYTES   = 46;
   localparam int RECON_HDR_BYTES = 8;

   localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
   localparam logic [7:0]  IPPROTO_UDP    = 8'd17;
   localparam logic [3:0]  IP_VERSION_4   = 4'd4;

   typedef enum logic [1:0] {
      HEAD = 2'd0,   // waiting for the first beat of a frame
      PASS = 2'd1,   // forwarding the rest of a matching frame
      DROP = 2'd2    // discarding the rest of a non-matching frame
   } filt_state_t;

endpackage

// File: rtl/axis_skid_buf.sv
// ---------------------------------------------------------------------------
// axis_skid_buf
// Two-entry AXI-Stream buffer with registered storage. A beat written in one
// cycle is presented on the output in the next cycle, and one beat per cycle
// streams through while the downstream side stays ready.
// Ports:
//   clk, rst             clock / synchronous active-high reset (flushes)
//   s_t*_i / s_tready_o  upstream side; s_tready_o = buffer not full
//   m_t*_o / m_tready_i  downstream side; m_tvalid_o = buffer not empty
// ---------------------------------------------------------------------------
module axis_skid_buf #(
   parameter int DATA_WIDTH = 512,
   parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] s_tdata_i,
   input  logic [KEEP_WIDTH-1:0] s_tkeep_i,
   input  logic                  s_tlast_i,
   input  logic                  s_tvalid_i,
   output logic                  s_tready_o,
   output logic [DATA_WIDTH-1:0] m_tdata_o,
   output logic [KEEP_WIDTH-1:0] m_tkeep_o,
   output logic                  m_tlast_o,
   output logic                  m_tvalid_o,
   input  logic                  m_tready_i
);

   localparam int ENTRY_W = DATA_WIDTH + KEEP_WIDTH + 1;

   logic [ENTRY_W-1:0] mem_q [2];
   logic               wr_ptr_q;
   logic               rd_ptr_q;
   logic [1:0]         count_q;
   logic [1:0]         count_d;
   logic               push;
   logic               pop;

   assign s_tready_o = (count_q != 2'd2);
   assign m_tvalid_o = (count_q != 2'd0);
   assign push       = s_tvalid_i && s_tready_o;
   assign pop        = m_tvalid_o && m_tready_i;

   always_comb begin
      count_d = count_q + {1'b0, push} - {1'b0, pop};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (push) wr_ptr_q <= ~wr_ptr_q;
         if (pop)  rd_ptr_q <= ~rd_ptr_q;
         count_q <= count_d;
      end
   end

   // Payload storage needs no reset: count_q alone decides what is valid.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {s_tlast_i, s_tkeep_i, s_tdata_i};
   end

   assign {m_tlast_o, m_tkeep_o, m_tdata_o} = mem_q[rd_ptr_q];

endmodule

// File: rtl/recon_frame_filter.sv
// ---------------------------------------------------------------------------
// recon_frame_filter
// Ingress filter in front of the bitstream stream-capture block. Beat 0 of
// each AXI-Stream frame is classified (Ethernet II / IPv4 / UDP / recon
// destination port / header bytes present); matching frames are forwarded
// bit-exact through a 2-entry buffer, everything else is silently dropped.
// Ports:
//   clk, rst           clock / synchronous active-high reset
//   s_axis_*           ingress stream from the MAC/RX path
//   m_axis_*           filtered stream towards the capture block
//   frame_pass/drop    registered one-cycle pulse per classified frame
// Optional build macro RECON_FILTER_STATS_EN adds:
//   stat_clr           synchronous clear of both counters (wins over increment)
//   stat_pass_cnt/     saturating 32-bit counts of frame_pass / frame_drop
//   stat_drop_cnt
// ---------------------------------------------------------------------------
module recon_frame_filter
   import recon_pkg::*;
#(
   parameter int          DATA_WIDTH     = 512,
   parameter int          KEEP_WIDTH     = DATA_WIDTH / 8,
   parameter logic [15:0] RECON_UDP_PORT = 16'h4D52,
   parameter int          MIN_HDR_BYTES  = RMT_HDR_BYTES + RECON_HDR_BYTES
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
   input  logic                  s_axis_tvalid,
   input  logic                  s_axis_tlast,
   output logic                  s_axis_tready,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
   output logic                  m_axis_tvalid,
   output logic                  m_axis_tlast,
   input  logic                  m_axis_tready,
   output logic                  frame_pass,
`ifdef RECON_FILTER_STATS_EN
   input  logic                  stat_clr,
   output logic [31:0]           stat_pass_cnt,
   output logic [31:0]           stat_drop_cnt,
`endif
   output logic                  frame_drop
);

   filt_state_t state_q, state_d;
   logic        pass_q, pass_d;
   logic        drop_q, drop_d;
   logic        buf_ready;
   logic        buf_valid_in;
   logic        s_fire;
   logic        hdr_match;

   logic [15:0] eth_type;
   logic [3:0]  ip_ver;
   logic [7:0]  ip_proto;
   logic [15:0] udp_dport;
   logic        keep_ok;

   // Header fields are big-endian on the wire: lower byte index = MSB.
   assign eth_type  = {s_axis_tdata[8*ETH_TYPE_OFS +: 8],
                       s_axis_tdata[8*(ETH_TYPE_OFS+1) +: 8]};
   assign ip_ver    = s_axis_tdata[8*IP_VER_OFS+4 +: 4];
   assign ip_proto  = s_axis_tdata[8*IP_PROTO_OFS +: 8];
   assign udp_dport = {s_axis_tdata[8*UDP_DPORT_OFS +: 8],
                       s_axis_tdata[8*(UDP_DPORT_OFS+1) +: 8]};
   assign keep_ok   = &s_axis_tkeep[MIN_HDR_BYTES-1:0];

   assign hdr_match = (eth_type == ETHERTYPE_IPV4) && (ip_ver == IP_VERSION_4) &&
                      (ip_proto == IPPROTO_UDP) && (udp_dport == RECON_UDP_PORT) &&
                      keep_ok;

   // Ready never looks at hdr_match: in HEAD a beat is taken whenever the
   // buffer has room, and its fate is decided in that same cycle.
   assign s_axis_tready = !rst && ((state_q == DROP) || buf_ready);
   assign s_fire        = s_axis_tvalid && s_axis_tready;
   assign buf_valid_in  = s_axis_tvalid && !rst &&
                          ((state_q == PASS) || ((state_q == HEAD) && hdr_match));

   always_comb begin
      state_d = state_q;
      pass_d  = 1'b0;
      drop_d  = 1'b0;
      if (s_fire) begin
         case (state_q)
            HEAD: begin
               if (hdr_match) begin
                  pass_d = 1'b1;
                  if (!s_axis_tlast) state_d = PASS;
               end else begin
                  drop_d = 1'b1;
                  if (!s_axis_tlast) state_d = DROP;
               end
            end
            PASS:    if (s_axis_tlast) state_d = HEAD;
            DROP:    if (s_axis_tlast) state_d = HEAD;
            default: state_d = HEAD;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= HEAD;
         pass_q  <= 1'b0;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pass_q  <= pass_d;
         drop_q  <= drop_d;
      end
   end

   assign frame_pass = pass_q;
   assign frame_drop = drop_q;

   axis_skid_buf #(
      .DATA_WIDTH (DATA_WIDTH),
      .KEEP_WIDTH (KEEP_WIDTH)
   ) u_skid (
      .clk        (clk),
      .rst        (rst),
      .s_tdata_i  (s_axis_tdata),
      .s_tkeep_i  (s_axis_tkeep),
      .s_tlast_i  (s_axis_tlast),
      .s_tvalid_i (buf_valid_in),
      .s_tready_o (buf_ready),
      .m_tdata_o  (m_axis_tdata),
      .m_tkeep_o  (m_axis_tkeep),
      .m_tlast_o  (m_axis_tlast),
      .m_tvalid_o (m_axis_tvalid),
      .m_tready_i (m_axis_tready)
   );

`ifdef RECON_FILTER_STATS_EN
   logic [31:0] pass_cnt_q;
   logic [31:0] drop_cnt_q;

   always_ff @(posedge clk) begin
      if (rst || stat_clr) begin
         pass_cnt_q <= '0;
         drop_cnt_q <= '0;
      end else begin
         if (pass_q && (pass_cnt_q != 32'hFFFF_FFFF)) pass_cnt_q <= pass_cnt_q + 32'd1;
         if (drop_q && (drop_cnt_q != 32'hFFFF_FFFF)) drop_cnt_q <= drop_cnt_q + 32'd1;
      end
   end

   assign stat_pass_cnt = pass_cnt_q;
   assign stat_drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_recon_frame_filter.sv
// ---------------------------------------------------------------------------
// tb_recon_frame_filter
// Scoreboard bench: the stimulus side classifies each frame with a byte-level
// reference model and queues the expected output beats and pulses; a monitor
// running on the falling edge pops and compares whatever the DUT presents.
// ---------------------------------------------------------------------------
module tb_recon_frame_filter;

   localparam int DW = 512;
   localparam int KW = DW / 8;

   logic          clk;
   logic          rst;
   logic [DW-1:0] s_axis_tdata;
   logic [KW-1:0] s_axis_tkeep;
   logic          s_axis_tvalid;
   logic          s_axis_tlast;
   logic          s_axis_tready;
   logic [DW-1:0] m_axis_tdata;
   logic [KW-1:0] m_axis_tkeep;
   logic          m_axis_tvalid;
   logic          m_axis_tlast;
   logic          m_axis_tready;
   logic          frame_pass;
   logic          frame_drop;
`ifdef RECON_FILTER_STATS_EN
   logic          stat_clr;
   logic [31:0]   stat_pass_cnt;
   logic [31:0]   stat_drop_cnt;
`endif

   recon_frame_filter dut (
      .clk           (clk),
      .rst           (rst),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tkeep  (s_axis_tkeep),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tready (s_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tkeep  (m_axis_tkeep),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tready (m_axis_tready),
      .frame_pass    (frame_pass),
`ifdef RECON_FILTER_STATS_EN
      .stat_clr      (stat_clr),
      .stat_pass_cnt (stat_pass_cnt),
      .stat_drop_cnt (stat_drop_cnt),
`endif
      .frame_drop    (frame_drop)
   );

   int checks = 0;
   int errors = 0;

   logic [DW+KW:0] exp_q[$];     // {tlast, tkeep, tdata} of beats due downstream
   bit             pulse_q[$];   // 1 = pass pulse due, 0 = drop pulse due
   logic [DW-1:0]  f_data[$];    // frame under construction
   logic [KW-1:0]  f_keep[$];
   int             model_pass = 0;
   int             model_drop = 0;
   int             mode = 0;     // m_axis_tready: 0 high, 1 random, 2 low, 3 pattern 1,0,0,1

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete (got timeout, required finish)");
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] rand_data();
      logic [DW-1:0] d;
      for (int i = 0; i < DW / 32; i++) d[32*i +: 32] = $urandom();
      return d;
   endfunction

   function automatic logic [KW-1:0] ones(input int n);
      logic [KW-1:0] r = '0;
      for (int i = 0; i < n; i++) r[i] = 1'b1;
      return r;
   endfunction

   // Reference classification straight from the frame's bytes.
   function automatic bit ref_match(input logic [DW-1:0] d, input logic [KW-1:0] k);
      logic [7:0] b [KW];
      bit keep_ok = 1'b1;
      for (int i = 0; i < KW; i++) b[i] = d[8*i +: 8];
      for (int i = 0; i < 54; i++) if (!k[i]) keep_ok = 1'b0;
      return (b[12] == 8'h08) && (b[13] == 8'h00) && (b[14][7:4] == 4'd4) &&
             (b[23] == 8'd17) && (b[36] == 8'h4D) && (b[37] == 8'h52) && keep_ok;
   endfunction

   // kind: 0 match, 1 bad port, 2 bad ethertype, 3 bad IP version,
   //       4 bad protocol, 5 runt (53 keep bytes), 6 raw random
   task automatic build_frame(input int kind, input int nbeats, input int keep_ones);
      logic [DW-1:0] d;
      logic [KW-1:0] k;
      logic [3:0]    nib;
      f_data.delete();
      f_keep.delete();
      for (int i = 0; i < nbeats; i++) begin
         d = rand_data();
         k = {$urandom(), $urandom()};
         if (i == 0) begin
            if (kind != 6) begin
               nib = 4'($urandom_range(0, 15));
               d[8*12 +: 8] = 8'h08;
               d[8*13 +: 8] = 8'h00;
               d[8*14 +: 8] = {4'h4, nib};
               d[8*23 +: 8] = 8'd17;
               d[8*36 +: 8] = 8'h4D;
               d[8*37 +: 8] = 8'h52;
               case (kind)
                  1: begin d[8*36 +: 8] = 8'h12; d[8*37 +: 8] = 8'h34; end
                  2: begin d[8*12 +: 8] = 8'h86; d[8*13 +: 8] = 8'hDD; end
                  3: d[8*14 +: 8] = 8'h65;
                  4: d[8*23 +: 8] = 8'd6;
                  default: ;
               endcase
            end
            k = ones((kind == 5) ? 53 : keep_ones);
         end
         f_data.push_back(d);
         f_keep.push_back(k);
      end
   endtask

   task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l,
                            output bit acc, output int waits);
      s_axis_tdata  = d;
      s_axis_tkeep  = k;
      s_axis_tlast  = l;
      s_axis_tvalid = 1'b1;
      acc   = 1'b0;
      waits = 0;
      while (!acc && waits < 300) begin
         @(negedge clk);
         if (s_axis_tready) acc = 1'b1;
         else waits++;
         @(posedge clk);
         #1;
      end
      // Idle bus carries garbage so an ignored tvalid=0 beat is visible if used.
      s_axis_tvalid = 1'b0;
      s_axis_tdata  = rand_data();
      s_axis_tkeep  = {$urandom(), $urandom()};
      s_axis_tlast  = 1'($urandom_range(0, 1));
      if (!acc) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: got no s_axis_tready in %0d cycles, required accept", waits);
      end
   endtask

   task automatic send_frame(input bit gaps, input int stop_after, input bit chk_lat);
      bit m;
      bit acc;
      int waits;
      int n;
      n = f_data.size();
      m = ref_match(f_data[0], f_keep[0]);
      for (int i = 0; i < n && i < stop_after; i++) begin
         if (gaps && i > 0 && $urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
         end
         send_beat(f_data[i], f_keep[i], (i == n - 1), acc, waits);
         if (!acc) return;
         if (i == 0) begin
            pulse_q.push_back(m);
            if (m) model_pass++;
            else   model_drop++;
         end
         if (m) exp_q.push_back({(i == n - 1), f_keep[i], f_data[i]});
         if (!m && i > 0) check("drop_ready_waits", 64'(waits), 64'd0);
         if (chk_lat && i == 0) begin
            check("latency_tvalid", 64'(m_axis_tvalid), 64'd1);
            check("latency_tdata_lo", m_axis_tdata[63:0], f_data[0][63:0]);
         end
         $display("beat %0d/%0d match=%0b waits=%0d last=%0b", i, n, m, waits, (i == n - 1));
      end
   endtask

   // Downstream ready generator.
   initial begin
      int phase = 0;
      logic [3:0] pat = 4'b1001;
      m_axis_tready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (mode)
            0: m_axis_tready = 1'b1;
            1: m_axis_tready = 1'($urandom_range(0, 1));
            2: m_axis_tready = 1'b0;
            default: begin
               m_axis_tready = pat[3 - (phase % 4)];
               phase++;
            end
         endcase
      end
   end

   // Monitor: compares every downstream transfer and every pulse.
   initial begin
      logic [DW+KW:0] e;
      bit             p;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (m_axis_tvalid && m_axis_tready) begin
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_beat: got beat tdata[63:0]=%h, required none", m_axis_tdata[63:0]);
               end else begin
                  e = exp_q.pop_front();
                  if ({m_axis_tlast, m_axis_tkeep, m_axis_tdata} !== e) begin
                     errors++;
                     $display("FAIL beat_data: got %h required %h",
                              {m_axis_tlast, m_axis_tkeep, m_axis_tdata}, e);
                  end
               end
            end
            if (frame_pass || frame_drop) begin
               checks++;
               if (pulse_q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_pulse: got pass=%0b drop=%0b, required none", frame_pass, frame_drop);
               end else begin
                  p = pulse_q.pop_front();
                  if (frame_pass !== p || frame_drop !== !p) begin
                     errors++;
                     $display("FAIL pulse_kind: got pass=%0b drop=%0b required pass=%0b drop=%0b",
                              frame_pass, frame_drop, p, !p);
                  end
               end
            end
         end
      end
   end

   initial begin
      rst           = 1'b1;
      s_axis_tdata  = '0;
      s_axis_tkeep  = '0;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
`ifdef RECON_FILTER_STATS_EN
      stat_clr      = 1'b0;
`endif
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_s_tready", 64'(s_axis_tready), 64'd0);
      check("reset_m_tvalid", 64'(m_axis_tvalid), 64'd0);
      check("reset_frame_pass", 64'(frame_pass), 64'd0);
      check("reset_frame_drop", 64'(frame_drop), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("post_reset_s_tready", 64'(s_axis_tready), 64'd1);
      @(posedge clk);
      #1;

      // Matching 3-beat frame, latency checked on beat 0.
      build_frame(0, 3, 64);  send_frame(0, 99, 1);
      // Bad port, 4 beats, then a matching frame.
      build_frame(1, 4, 64);  send_frame(0, 99, 0);
      build_frame(0, 3, 64);  send_frame(0, 99, 0);
      // Single-beat frames at the keep boundary.
      build_frame(0, 1, 54);  send_frame(0, 99, 0);
      build_frame(0, 1, 53);  send_frame(0, 99, 0);
      build_frame(0, 2, 53);  send_frame(0, 99, 0);

      // Back-pressure: buffer fills, ingress must stall.
      mode = 2;
      build_frame(0, 4, 64);
      fork
         send_frame(0, 99, 0);
         begin
            repeat (6) @(negedge clk);
            check("bp_s_tready_low", 64'(s_axis_tready), 64'd0);
            check("bp_m_tvalid_high", 64'(m_axis_tvalid), 64'd1);
            @(posedge clk);
            #1;
            mode = 3;
         end
      join
      build_frame(0, 3, 64);  send_frame(0, 99, 0);
      build_frame(0, 2, 64);  send_frame(0, 99, 0);

      // Reset during beat 2 of a 5-beat passing frame.
      mode = 0;
      repeat (4) @(posedge clk);
      #1;
      build_frame(0, 5, 64);
      send_frame(0, 2, 0);
      rst = 1'b1;
      s_axis_tdata  = f_data[2];
      s_axis_tkeep  = f_keep[2];
      s_axis_tlast  = 1'b0;
      s_axis_tvalid = 1'b1;
      exp_q.delete();
      pulse_q.delete();
      model_pass = 0;
      model_drop = 0;
      @(negedge clk);
      check("midrst_s_tready", 64'(s_axis_tready), 64'd0);
      @(posedge clk);
      #1;
      check("midrst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
      rst = 1'b0;
      s_axis_tvalid = 1'b0;
      @(negedge clk);
      check("midrst_after_s_tready", 64'(s_axis_tready), 64'd1);
      @(posedge clk);
      #1;
      build_frame(0, 3, 64);  send_frame(0, 99, 0);

      // Randomised traffic with random back-pressure and ingress gaps.
      mode = 1;
      for (int f = 0; f < 40; f++) begin
         int kind;
         kind = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 6));
         build_frame(kind, int'($urandom_range(1, 6)), 64);
         send_frame(1, 99, 0);
         $display("frame %0d kind=%0d done", f, kind);
      end

      mode = 0;
      for (int t = 0; t < 200 && (exp_q.size() != 0 || pulse_q.size() != 0); t++) @(posedge clk);
      repeat (3) @(posedge clk);
      #1;

`ifdef RECON_FILTER_STATS_EN
      check("stat_pass_cnt", 64'(stat_pass_cnt), 64'(model_pass));
      check("stat_drop_cnt", 64'(stat_drop_cnt), 64'(model_drop));
      build_frame(0, 1, 64);
      send_frame(0, 99, 0);
      stat_clr = 1'b1;
      @(posedge clk);
      #1;
      stat_clr = 1'b0;
      check("stat_clr_pass", 64'(stat_pass_cnt), 64'd0);
      check("stat_clr_drop", 64'(stat_drop_cnt), 64'd0);
      repeat (3) @(posedge clk);
      #1;
`endif

      check("drain_beats_left", 64'(exp_q.size()), 64'd0);
      check("drain_pulses_left", 64'(pulse_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
